// File: rtl/rv_decode_stage_if.sv
// rv_decode_stage_if: fetch-to-decode and decode-to-execute handshake bundle.
// The decode stage takes the slave modport; the fetch/execute side drives master.
interface rv_decode_stage_if #(parameter int XLEN = 32);
    logic            in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [XLEN-1:0] pc_in, ins_in, pc_out, ins_out, imm;
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    modport master (
        output in_valid, pc_in, ins_in, flush, out_ready,
        input  in_ready, out_valid, pc_out, ins_out, opcode, rd, funct3, rs1, rs2, funct7, imm, illegal
    );
    modport slave (
        input  in_valid, pc_in, ins_in, flush, out_ready,
        output in_ready, out_valid, pc_out, ins_out, opcode, rd, funct3, rs1, rs2, funct7, imm, illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I decode with output + skid register, flush for redirect.
// Optional DECODE_STATS_EN adds stat_issued/stat_illegal dequeue counters.
module rv_decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst_n,
    rv_decode_stage_if.slave bus
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_illegal
`endif
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;

    logic [XLEN-1:0] ins, dec_imm;
    logic [6:0]      op, f7;
    logic            is_i, is_s, is_b, is_u, is_j, known, dec_ill;

    logic            ov, sv;
    logic [XLEN-1:0] pc_r, ins_r, imm_r, pc_s, ins_s, imm_s;
    logic            ill_r, ill_s;
    logic            acc, deq;

    assign ins  = bus.ins_in;
    assign op   = ins[6:0];
    assign f7   = ins[31:25];
    assign is_i = op == OP_LOAD || op == OP_IMM || op == OP_JALR || op == OP_SYSTEM;
    assign is_s = op == OP_STORE;
    assign is_b = op == OP_BRANCH;
    assign is_u = op == OP_LUI || op == OP_AUIPC;
    assign is_j = op == OP_JAL;
    assign known = is_i || is_s || is_b || is_u || is_j || op == OP_OP || op == OP_MISC;

    // Illegal encodings get imm=0 naturally: an unknown opcode matches no format.
    assign dec_imm = is_i ? {{20{ins[31]}}, ins[31:20]} :
                     is_s ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                     is_b ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                     is_u ? {ins[31:12], 12'b0} :
                     is_j ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
                     '0;

    assign dec_ill = ins[1:0] != 2'b11 || !known || ins == '0 || ins == '1 ||
                     (op == OP_OP && f7 != 7'b0000000 && f7 != 7'b0100000);

    assign acc = bus.in_valid && bus.in_ready;
    assign deq = ov && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov <= 1'b0;
            sv <= 1'b0;
        end else if (bus.flush) begin
            ov <= 1'b0;
            sv <= 1'b0;
        end else if (deq && sv) begin
            sv <= 1'b0;
        end else if (acc && (!ov || deq)) begin
            ov <= 1'b1;
        end else if (acc) begin
            sv <= 1'b1;
        end else if (deq) begin
            ov <= 1'b0;
        end
    end

    // Data registers ignore flush; only the valid bits decide what is live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r  <= RESET_PC;
            ins_r <= '0;
            imm_r <= '0;
            ill_r <= 1'b0;
            pc_s  <= '0;
            ins_s <= '0;
            imm_s <= '0;
            ill_s <= 1'b0;
        end else if (!bus.flush) begin
            if (deq && sv) begin
                pc_r  <= pc_s;
                ins_r <= ins_s;
                imm_r <= imm_s;
                ill_r <= ill_s;
            end else if (acc && (!ov || deq)) begin
                pc_r  <= bus.pc_in;
                ins_r <= ins;
                imm_r <= dec_imm;
                ill_r <= dec_ill;
            end
            if (acc && ov && !deq) begin
                pc_s  <= bus.pc_in;
                ins_s <= ins;
                imm_s <= dec_imm;
                ill_s <= dec_ill;
            end
        end
    end

`ifdef DECODE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else if (deq) begin
            stat_issued  <= stat_issued + 32'd1;
            stat_illegal <= stat_illegal + {31'd0, ill_r};
        end
    end
`endif

    assign bus.in_ready  = !sv;
    assign bus.out_valid = ov;
    assign bus.pc_out    = pc_r;
    assign bus.ins_out   = ins_r;
    assign bus.opcode    = ins_r[6:0];
    assign bus.rd        = ins_r[11:7];
    assign bus.funct3    = ins_r[14:12];
    assign bus.rs1       = ins_r[19:15];
    assign bus.rs2       = ins_r[24:20];
    assign bus.funct7    = ins_r[31:25];
    assign bus.imm       = imm_r;
    assign bus.illegal   = ill_r;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed vectors with hand-computed decode results.
// Define DECODE_STATS_EN to also check the dequeue counters.
module tb_rv_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    rv_decode_stage_if bus ();
`ifdef DECODE_STATS_EN
    logic [31:0] stat_issued, stat_illegal;
`endif

    rv_decode_stage dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef DECODE_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_illegal(stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ins);
        bus.in_valid = 1'b1;
        bus.pc_in    = pc;
        bus.ins_in   = ins;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.pc_in     = '0;
        bus.ins_in    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_pc_out", bus.pc_out, 32'h0);
        check("rst_imm", bus.imm, 32'h0);
        check("rst_ins_out", bus.ins_out, 32'h0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        step();
        step();
        rst_n = 1'b1;

        send(32'h4, 32'h00500093);
        check("addi_valid", {31'd0, bus.out_valid}, 32'd1);
        check("addi_opcode", {25'd0, bus.opcode}, 32'h13);
        check("addi_rd", {27'd0, bus.rd}, 32'd1);
        check("addi_rs1", {27'd0, bus.rs1}, 32'd0);
        check("addi_funct3", {29'd0, bus.funct3}, 32'd0);
        check("addi_imm", bus.imm, 32'h5);
        check("addi_pc", bus.pc_out, 32'h4);
        check("addi_illegal", {31'd0, bus.illegal}, 32'd0);
        step();
        check("addi_drained", {31'd0, bus.out_valid}, 32'd0);

        bus.out_ready = 1'b0;
        send(32'h8, 32'h00500093);
        check("bp_first_ready", {31'd0, bus.in_ready}, 32'd1);
        send(32'hC, 32'hFFF10113);
        check("bp_skid_full", {31'd0, bus.in_ready}, 32'd0);
        check("bp_hold_pc", bus.pc_out, 32'h8);
        step();
        check("bp_hold_pc2", bus.pc_out, 32'h8);
        check("bp_hold_ins", bus.ins_out, 32'h00500093);
        check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp_second_pc", bus.pc_out, 32'hC);
        check("bp_second_rd", {27'd0, bus.rd}, 32'd2);
        check("bp_second_rs1", {27'd0, bus.rs1}, 32'd2);
        check("bp_second_imm", bus.imm, 32'hFFFFFFFF);
        check("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_ready_back", {31'd0, bus.in_ready}, 32'd1);
        step();
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        send(32'h40, 32'hFE000EE3);
        check("beq_imm", bus.imm, 32'hFFFFFFFC);
        check("beq_opcode", {25'd0, bus.opcode}, 32'h63);
        send(32'h44, 32'h008000EF);
        check("jal_rd", {27'd0, bus.rd}, 32'd1);
        check("jal_imm", bus.imm, 32'h8);
        check("jal_pc", bus.pc_out, 32'h44);
        send(32'h48, 32'h123452B7);
        check("lui_rd", {27'd0, bus.rd}, 32'd5);
        check("lui_imm", bus.imm, 32'h12345000);
        send(32'h4C, 32'h0020A423);
        check("sw_imm", bus.imm, 32'h8);
        check("sw_rs2", {27'd0, bus.rs2}, 32'd2);
        send(32'h50, 32'h40208033);
        check("sub_illegal", {31'd0, bus.illegal}, 32'd0);
        check("sub_funct7", {25'd0, bus.funct7}, 32'h20);
        check("sub_imm", bus.imm, 32'h0);
        send(32'h54, 32'h02208033);
        check("op_f7_illegal", {31'd0, bus.illegal}, 32'd1);
        step();

        bus.out_ready = 1'b0;
        send(32'h10, 32'h00500093);
        send(32'h14, 32'hFFF10113);
        check("fl_full", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b1;
        bus.pc_in    = 32'h18;
        bus.ins_in   = 32'h0020A423;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("fl_stays_empty", {31'd0, bus.out_valid}, 32'd0);
        bus.flush = 1'b1;
        send(32'h1C, 32'h00500093);
        bus.flush = 1'b0;
        check("fl_drop_input", {31'd0, bus.out_valid}, 32'd0);
        send(32'h20, 32'h0020A423);
        check("fl_recover_pc", bus.pc_out, 32'h20);
        check("fl_recover_valid", {31'd0, bus.out_valid}, 32'd1);
        step();

        bus.out_ready = 1'b0;
        send(32'h30, 32'h00500093);
        send(32'h34, 32'hFFF10113);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mrst_pc_out", bus.pc_out, 32'h0);
        check("mrst_imm", bus.imm, 32'h0);
`ifdef DECODE_STATS_EN
        check("mrst_stat_issued", stat_issued, 32'd0);
        check("mrst_stat_illegal", stat_illegal, 32'd0);
`endif
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;

        send(32'h60, 32'h00000000);
        check("ill_zero", {31'd0, bus.illegal}, 32'd1);
        check("ill_zero_valid", {31'd0, bus.out_valid}, 32'd1);
        send(32'h64, 32'hFFFFFFFF);
        check("ill_ones", {31'd0, bus.illegal}, 32'd1);
        check("ill_ones_valid", {31'd0, bus.out_valid}, 32'd1);
        send(32'h68, 32'h0000007F);
        check("ill_opcode", {31'd0, bus.illegal}, 32'd1);
        check("ill_opcode_valid", {31'd0, bus.out_valid}, 32'd1);
        check("ill_opcode_imm", bus.imm, 32'h0);
        step();
        check("ill_drained", {31'd0, bus.out_valid}, 32'd0);
`ifdef DECODE_STATS_EN
        check("stat_issued", stat_issued, 32'd3);
        check("stat_illegal", stat_illegal, 32'd3);
        send(32'h6C, 32'h00500093);
        step();
        check("stat_issued_legal", stat_issued, 32'd4);
        check("stat_illegal_legal", stat_illegal, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Decode stage directly downstream of the RV1 fetch/Insmem path.
- Accepts {pc, instruction} from fetch through a valid/ready handshake.
- Decodes RV32I fields and the sign-extended immediate, then registers the result for execute.
- A 2-entry buffer (output register plus skid register) keeps in_ready registered and loses nothing under backpressure; flush supports branch redirect.

Parameters:
XLEN, 32, datapath width; only 32 supported.
RESET_PC, 32'h0, reset value of pc_out.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents pc_in/ins_in
in_ready  out  1  stage can accept; equals !skid_valid
pc_in  in  32  PC of instruction
ins_in  in  32  raw instruction from Insmem
flush  in  1  synchronous kill of all held and incoming entries
out_valid  out  1  decoded entry present
out_ready  in  1  execute accepts entry
pc_out  out  32  PC of entry
ins_out  out  32  raw instruction of entry
opcode  out  7  ins[6:0]
rd  out  5  ins[11:7]
funct3  out  3  ins[14:12]
rs1  out  5  ins[19:15]
rs2  out  5  ins[24:20]
funct7  out  7  ins[31:25]
imm  out  32  sign-extended immediate
illegal  out  1  entry is not a legal RV32I encoding

Behaviour:
- Reset (rst_n=0, async): out_valid=0, skid_valid=0, in_ready=1, pc_out=RESET_PC, all other outputs 0.
- Decode is combinational on ins_in and captured into R (output reg) or S (skid reg). Latency is 1 cycle from accept to out_valid.
- Accept condition: in_valid && in_ready.
- Dequeue condition: out_valid && out_ready.
- Per cycle, with flush=0:
  - dequeue && skid_valid: R<=S, skid_valid<=0. An accept in this cycle is impossible because in_ready=0.
  - accept && (!out_valid || dequeue): R<=decoded input, out_valid<=1.
  - accept && out_valid && !dequeue: S<=decoded input, skid_valid<=1. out_valid stays 1.
  - dequeue && !accept && !skid_valid: out_valid<=0.
- Output fields hold while out_valid && !out_ready. No field may change until dequeue.
- flush=1 has highest priority: out_valid<=0 and skid_valid<=0 next cycle. Input presented that cycle is dropped. Data regs may keep stale values.
- Immediate selection by opcode:
  - I-type (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): sext(ins[31:20]).
  - S-type (STORE 0100011): sext({ins[31:25],ins[11:7]}).
  - B-type (BRANCH 1100011): sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - U-type (LUI 0110111, AUIPC 0010111): {ins[31:12],12'b0}.
  - J-type (JAL 1101111): sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
  - OP 0110011, MISC-MEM 0001111, and illegal encodings: imm=0.
- illegal=1 when any of:
  - ins[1:0]!=2'b11
  - opcode not in the list above
  - ins==32'h0
  - ins==32'hFFFFFFFF
  - OP with funct7 not in {0000000, 0100000}
- Illegal entries still flow through the handshake. Execute decides whether to trap.
- Mid-operation reset clears both entries immediately; no partial entry survives.

Optional Feature:
DECODE_STATS_EN
- Defined:
  - Adds outputs stat_issued[31:0] and stat_illegal[31:0].
  - stat_issued increments on each dequeue; stat_illegal increments on dequeue when illegal=1.
  - Counters wrap modulo 2^32, reset to 0 on rst_n, and are unaffected by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> out_valid=0 and in_ready=1 immediately, pc_out=0, imm=0.
2. ADDI: ins_in=32'h00500093, pc_in=32'h4, in_valid=1, out_ready=1 -> next cycle out_valid=1, opcode=7'h13, rd=1, rs1=0, funct3=0, imm=32'h5, pc_out=32'h4, illegal=0.
3. Backpressure: out_ready=0, send 32'h00500093 then 32'hFFF10113 -> in_ready=0 after the second accept; raise out_ready -> outputs appear in order, the second with rd=2, rs1=2, imm=32'hFFFFFFFF; in_ready returns to 1 once skid_valid clears.
4. Immediates:
   - BEQ 32'hFE000EE3 -> imm=32'hFFFFFFFC
   - JAL 32'h008000EF -> rd=1, imm=32'h8
   - LUI 32'h123452B7 -> rd=5, imm=32'h12345000
5. Flush: both entries full plus in_valid=1, assert flush=1 for one cycle -> next cycle out_valid=0, in_ready=1; the flushed-cycle instruction never appears at the output.
6. Illegal: ins_in=32'h00000000, then 32'hFFFFFFFF, then 32'h0000007F -> illegal=1 on each with out_valid=1; with DECODE_STATS_EN defined, after the three dequeues stat_illegal=3 and stat_issued=3.
